// File: rtl/xout_rr_arbiter_pkg.sv
// Shared types and the rotate/priority/unrotate pick used by the arbiter.
// Latency: none (types and constant/combinational helpers only).
// Backpressure: not applicable.
package xout_arb_pkg;

  // Largest supported requester count and the index width that covers it
  localparam int MAXREQ = 16;
  localparam int MAXIDX = 4;

  // Default configuration of the block
  localparam int NREQ_DEFAULT = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  typedef struct packed {
    logic              found;
    logic [MAXIDX-1:0] idx;
  } pick_t;

  // Index width for n requesters; a single requester still gets one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDXW = idx_width(NREQ_DEFAULT);

  // First set request at or after ptr, wrapping modulo nreq
  function automatic pick_t rr_pick(input logic [MAXREQ-1:0] req,
                                    input logic [MAXIDX-1:0] ptr,
                                    input int nreq);
    pick_t             r;
    logic [MAXREQ-1:0] rot;
    logic [MAXIDX:0]   j;
    r.found = 1'b0;
    r.idx   = '0;
    rot     = '0;
    // Rotate so that the requester at ptr lands on bit 0
    for (int k = 0; k < MAXREQ; k++) begin
      j = {1'b0, ptr} + (MAXIDX+1)'(k);
      if (j >= (MAXIDX+1)'(nreq)) j = j - (MAXIDX+1)'(nreq);
      if (k < nreq) rot[MAXIDX'(k)] = req[j[MAXIDX-1:0]];
    end
    // Lowest set bit of the rotated vector wins; map it back to an index
    for (int k = MAXREQ-1; k >= 0; k--) begin
      if (rot[MAXIDX'(k)]) begin
        j = {1'b0, ptr} + (MAXIDX+1)'(k);
        if (j >= (MAXIDX+1)'(nreq)) j = j - (MAXIDX+1)'(nreq);
        r.found = 1'b1;
        r.idx   = j[MAXIDX-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/xout_rr_arbiter_if.sv
// Requester-side bus of the XOUT arbiter: requests, data, grant and output.
// Latency: none (wires only).
// Backpressure: requesters see GNT; non-owners simply wait.
interface xout_rr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 2
);
  logic [NREQ-1:0]       REQ;
  logic [NREQ*WIDTH-1:0] DIN;
  logic [NREQ-1:0]       GNT;
  logic [IDXW-1:0]       GNT_IDX;
  logic [WIDTH-1:0]      XOUT;
  logic                  XVALID;

  // Requester side drives REQ/DIN and observes the grant and output
  modport master (output REQ, DIN, input GNT, GNT_IDX, XOUT, XVALID);
  // Arbiter side
  modport slave  (input REQ, DIN, output GNT, GNT_IDX, XOUT, XVALID);
endinterface

// File: rtl/xout_rr_arbiter_pick.sv
// Round-robin pick: rotate requests to ptr, priority-encode, unrotate.
// Latency: combinational.
// Backpressure: not applicable.
module rr_priority_pick
  import xout_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  pick_t pk;

  // Widen to the package's maximum size and narrow the result back
  always_comb begin
    pk    = rr_pick(MAXREQ'(req), MAXIDX'(ptr), NREQ);
    found = pk.found;
    idx   = pk.idx[IDXW-1:0];
  end

endmodule

// File: rtl/xout_rr_arbiter.sv
// Round-robin owner of the shared XOUT register; owner streams one word/cycle.
// Latency: grant 1 edge after request seen in IDLE; data 1 edge after DIN sampled.
// Backpressure: grant held until REQ drops or MAX_HOLD words, then one dead cycle.
module xout_rr_arbiter
  import xout_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input logic              CLK,
  input logic              RESET,
  xout_rr_arbiter_if.slave bus
);

  localparam int AIDXW = idx_width(NREQ);
  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_OWN  = OWN;

  logic [0:0]       state;
  logic [AIDXW-1:0] ptr;
  logic [7:0]       hcnt;

  logic             pick_found;
  logic [AIDXW-1:0] pick_idx;
  logic [AIDXW-1:0] owner;
  logic             owner_req;
  logic [WIDTH-1:0] owner_dat;
  logic [7:0]       hcnt_nxt;
  logic [AIDXW-1:0] ptr_after;

  rr_priority_pick #(.NREQ(NREQ), .IDXW(AIDXW)) u_pick (
    .req   (bus.REQ),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Only the owner's lane is selected, so other lanes cannot leak into XOUT
  always_comb begin
    owner     = bus.GNT_IDX;
    owner_req = bus.REQ[owner];
    owner_dat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == AIDXW'(i)) owner_dat = bus.DIN[i*WIDTH +: WIDTH];
    end
    hcnt_nxt  = hcnt + 8'd1;
    ptr_after = (owner == AIDXW'(NREQ-1)) ? '0 : owner + 1'b1;
  end

  // Grant FSM, hold counter, rotation pointer and the XOUT register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      hcnt        <= '0;
      bus.GNT     <= '0;
      bus.GNT_IDX <= '0;
      bus.XOUT    <= '0;
      bus.XVALID  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.XVALID <= 1'b0;
          if (pick_found) begin
            bus.GNT     <= NREQ'(1) << pick_idx;
            bus.GNT_IDX <= pick_idx;
            hcnt        <= '0;
            state       <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (owner_req) begin
            bus.XOUT   <= owner_dat;
            bus.XVALID <= 1'b1;
            hcnt       <= hcnt_nxt;
          end else begin
            bus.XVALID <= 1'b0;
          end
          // Release on drop or on the last allowed word; that word still lands
          if (!owner_req || (hcnt_nxt == 8'(MAX_HOLD))) begin
            bus.GNT     <= '0;
            bus.GNT_IDX <= '0;
            ptr         <= ptr_after;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
